fma16_sched: RTL and testbench

//   Round-robin scheduler and sequencer that shares one combinational fma16 datapath among NREQ requesters.

---
 rtl/fma16_sched.sv | 207 ++++++++++++++++++++
 tb/tb_fma16_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma16_sched.sv
`default_nettype none
// ============================================================================
// Module   : fma16_sched
// Purpose  : Round-robin scheduler/sequencer that shares a single
//            combinational fma16 datapath among NREQ requesters. One op is
//            in flight at a time: accept -> EXEC (LAT cycles) -> RESP.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            req_valid/req_ready   - per-requester handshake (ready one-hot)
//            req_op/x/y/z/rm       - per-requester packed op, operands, rounding
//            fma_x/y/z/mul/add/negr/negz/rm - registered fma16 inputs
//            fma_result            - fma16 output, sampled at end of EXEC
//            resp_valid/ready/id/result/err - response handshake and payload
//            busy                  - scheduler not idle
// Revision : 1.0 - initial release
// ============================================================================
module fma16_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [3*NREQ-1:0]  req_op,
  input  logic [16*NREQ-1:0] req_x,
  input  logic [16*NREQ-1:0] req_y,
  input  logic [16*NREQ-1:0] req_z,
  input  logic [2*NREQ-1:0]  req_rm,
  output logic [15:0]        fma_x,
  output logic [15:0]        fma_y,
  output logic [15:0]        fma_z,
  output logic               fma_mul,
  output logic               fma_add,
  output logic               fma_negr,
  output logic               fma_negz,
  output logic [1:0]         fma_rm,
  input  logic [15:0]        fma_result,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [15:0]        resp_result,
  output logic               resp_err,
  output logic               busy
);

  localparam int              CW         = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0]   C_CNT_INIT = CW'(LAT - 1);
  localparam logic [15:0]     C_QNAN     = 16'h7E00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_fma_x, r_fma_y, r_fma_z;
  logic [3:0]      r_fma_flags;      // {mul, add, negr, negz}
  logic [1:0]      r_fma_rm;
  logic [IDW-1:0]  r_resp_id;
  logic [15:0]     r_resp_result;
  logic            r_resp_err;

  // ---------------------------------------------------------------------
  // Round-robin grant: pick the valid requester with the smallest forward
  // distance from the pointer. Distances are computed per constant index so
  // NREQ need not be a power of two.
  // ---------------------------------------------------------------------
  logic            w_gvalid;
  logic [IDW-1:0]  w_grant;
  int              w_best;

  always_comb begin
    w_best  = NREQ;
    w_grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (((i - int'(r_ptr) + NREQ) % NREQ) < w_best)) begin
        w_best  = (i - int'(r_ptr) + NREQ) % NREQ;
        w_grant = IDW'(i);
      end
    end
    w_gvalid = (w_best < NREQ);
  end

  // Slice out the granted requester's fields using constant part-selects.
  logic [2:0]  w_op;
  logic [15:0] w_x, w_y, w_z;
  logic [1:0]  w_rm;

  always_comb begin
    w_op = '0;
    w_x  = '0;
    w_y  = '0;
    w_z  = '0;
    w_rm = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_op = req_op[3*i +: 3];
        w_x  = req_x[16*i +: 16];
        w_y  = req_y[16*i +: 16];
        w_z  = req_z[16*i +: 16];
        w_rm = req_rm[2*i +: 2];
      end
    end
  end

  // Op decode to {mul, add, negr, negz}; 3'b111 is the only illegal code.
  logic [3:0] w_flags;
  logic       w_legal;

  always_comb begin
    w_flags = 4'b0000;
    w_legal = 1'b1;
    case (w_op)
      3'b000:  w_flags = 4'b0100;   // fadd
      3'b001:  w_flags = 4'b0101;   // fsub
      3'b010:  w_flags = 4'b1000;   // fmul
      3'b011:  w_flags = 4'b1100;   // fmadd
      3'b100:  w_flags = 4'b1101;   // fmsub
      3'b101:  w_flags = 4'b1110;   // fnmadd
      3'b110:  w_flags = 4'b1111;   // fnmsub
      default: w_legal = 1'b0;
    endcase
  end

  // Accept happens whenever IDLE sees any valid request; ready is gated by
  // reset so nothing is acknowledged that the reset branch would discard.
  logic            w_take;
  logic [IDW-1:0]  w_ptr_nxt;

  assign w_take    = (r_state == S_IDLE) && !reset && w_gvalid;
  assign w_ptr_nxt = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);
  assign req_ready = w_take ? (NREQ'(1) << w_grant) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_fma_x       <= '0;
      r_fma_y       <= '0;
      r_fma_z       <= '0;
      r_fma_flags   <= '0;
      r_fma_rm      <= '0;
      r_resp_id     <= '0;
      r_resp_result <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gvalid) begin
            r_resp_id <= w_grant;
            r_ptr     <= w_ptr_nxt;
            if (w_legal) begin
              r_fma_x     <= w_x;
              r_fma_y     <= w_y;
              r_fma_z     <= w_z;
              r_fma_flags <= w_flags;
              r_fma_rm    <= w_rm;
              r_cnt       <= C_CNT_INIT;
              r_state     <= S_EXEC;
            end else begin
              // Illegal op never reaches the datapath; answer with a qNaN.
              r_resp_result <= C_QNAN;
              r_resp_err    <= 1'b1;
              r_state       <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_resp_result <= fma_result;
            r_resp_err    <= 1'b0;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fma_x       = r_fma_x;
  assign fma_y       = r_fma_y;
  assign fma_z       = r_fma_z;
  assign fma_mul     = r_fma_flags[3];
  assign fma_add     = r_fma_flags[2];
  assign fma_negr    = r_fma_flags[1];
  assign fma_negz    = r_fma_flags[0];
  assign fma_rm      = r_fma_rm;
  assign resp_valid  = (r_state == S_RESP);
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;
  assign resp_err    = r_resp_err;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fma16_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fma16_sched
// Purpose  : Scoreboard bench for fma16_sched. A stand-in fma16 (operand hash)
//            makes every result traceable to operands, decode and roundmode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fma16_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 1;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (LAT=1)
  logic [NREQ-1:0]    req_valid = '0, req_ready;
  logic [3*NREQ-1:0]  req_op = '0;
  logic [16*NREQ-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic [2*NREQ-1:0]  req_rm = '0;
  logic [15:0]        fma_x, fma_y, fma_z, fma_result;
  logic               fma_mul, fma_add, fma_negr, fma_negz;
  logic [1:0]         fma_rm;
  logic               resp_valid, resp_ready = 1'b0, resp_err, busy;
  logic [IDW-1:0]     resp_id;
  logic [15:0]        resp_result;

  // Second DUT (LAT=3)
  logic [NREQ-1:0]    b_req_valid = '0, b_req_ready;
  logic [3*NREQ-1:0]  b_req_op = '0;
  logic [16*NREQ-1:0] b_req_x = '0, b_req_y = '0, b_req_z = '0;
  logic [2*NREQ-1:0]  b_req_rm = '0;
  logic [15:0]        b_fma_x, b_fma_y, b_fma_z, b_fma_result;
  logic               b_fma_mul, b_fma_add, b_fma_negr, b_fma_negz;
  logic [1:0]         b_fma_rm;
  logic               b_resp_valid, b_resp_ready = 1'b1, b_resp_err, b_busy;
  logic [IDW-1:0]     b_resp_id;
  logic [15:0]        b_resp_result;

  // Stand-in datapath: any wiring, decode or rounding-mode slip changes it.
  function automatic logic [15:0] fake_fma(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z, input logic [3:0] f,
                                           input logic [1:0] rm);
    return (x + {y[10:0], y[15:11]}) ^ {z[3:0], z[15:4]} ^ {f, 4'h0, 6'h0, rm};
  endfunction

  assign fma_result   = fake_fma(fma_x, fma_y, fma_z, {fma_mul, fma_add, fma_negr, fma_negz}, fma_rm);
  assign b_fma_result = fake_fma(b_fma_x, b_fma_y, b_fma_z,
                                 {b_fma_mul, b_fma_add, b_fma_negr, b_fma_negz}, b_fma_rm);

  fma16_sched #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rm(req_rm),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z), .fma_mul(fma_mul), .fma_add(fma_add),
    .fma_negr(fma_negr), .fma_negz(fma_negz), .fma_rm(fma_rm), .fma_result(fma_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_err(resp_err), .busy(busy)
  );

  fma16_sched #(.NREQ(NREQ), .LAT(3), .IDW(IDW)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op(b_req_op), .req_x(b_req_x), .req_y(b_req_y), .req_z(b_req_z), .req_rm(b_req_rm),
    .fma_x(b_fma_x), .fma_y(b_fma_y), .fma_z(b_fma_z), .fma_mul(b_fma_mul), .fma_add(b_fma_add),
    .fma_negr(b_fma_negr), .fma_negz(b_fma_negz), .fma_rm(b_fma_rm), .fma_result(b_fma_result),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_id(b_resp_id),
    .resp_result(b_resp_result), .resp_err(b_resp_err), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference decode table: {illegal, mul, add, negr, negz}
  function automatic logic [4:0] ref_dec(input logic [2:0] op);
    case (op)
      3'd0: return 5'b0_0100;
      3'd1: return 5'b0_0101;
      3'd2: return 5'b0_1000;
      3'd3: return 5'b0_1100;
      3'd4: return 5'b0_1101;
      3'd5: return 5'b0_1110;
      3'd6: return 5'b0_1111;
      default: return 5'b1_0000;
    endcase
  endfunction

  // ---------------- reference model state ----------------
  typedef struct {
    int          id;
    logic [15:0] res;
    logic        err;
    int          due;
  } exp_t;
  exp_t sbq[$];

  bit          p_has [NREQ];
  logic [2:0]  p_op  [NREQ];
  logic [15:0] p_x   [NREQ];
  logic [15:0] p_y   [NREQ];
  logic [15:0] p_z   [NREQ];
  logic [1:0]  p_rm  [NREQ];

  int          m_ptr = 0;
  bit          outstanding = 0;
  bit          clr_pend = 0;
  bit          seen_first = 0;
  int          wait_cnt = 0;
  bit          fma_chk = 0;
  logic [15:0] m_fx = '0, m_fy = '0, m_fz = '0;
  logic [3:0]  m_fl = '0;
  logic [1:0]  m_rm = '0;
  int          glog[$];

  always @(posedge clk) if (clr_pend) begin outstanding = 0; clr_pend = 0; end

  task automatic new_op(input int i);
    p_has[i] = 1;
    p_op[i]  = 3'($urandom_range(0, 7));
    p_x[i]   = 16'($urandom);
    p_y[i]   = 16'($urandom);
    p_z[i]   = 16'($urandom);
    p_rm[i]  = 2'($urandom_range(0, 3));
  endtask

  task automatic model_reset();
    sbq.delete();
    outstanding = 0; clr_pend = 0; seen_first = 0; fma_chk = 0; wait_cnt = 0;
    m_ptr = 0; m_fx = '0; m_fy = '0; m_fz = '0; m_fl = '0; m_rm = '0;
  endtask

  // Checks made at the negedge of every cycle driven by the bench.
  task automatic model_check();
    int g;
    logic [4:0] d;
    exp_t e;
    if (fma_chk) begin
      chk("fma_x", fma_x, m_fx);
      chk("fma_y", fma_y, m_fy);
      chk("fma_z", fma_z, m_fz);
      chk("fma_flags", {fma_mul, fma_add, fma_negr, fma_negz}, m_fl);
      chk("fma_rm", fma_rm, m_rm);
      fma_chk = 0;
    end
    if (!outstanding) begin
      g = -1;
      for (int k = NREQ - 1; k >= 0; k--)
        if (p_has[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      chk("req_ready_idle", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("busy_idle", busy, 0);
      if (g >= 0) begin
        d = ref_dec(p_op[g]);
        e.id = g;
        if (d[4]) begin
          e.res = 16'h7E00; e.err = 1'b1; e.due = cyc + 1;
        end else begin
          m_fx = p_x[g]; m_fy = p_y[g]; m_fz = p_z[g]; m_fl = d[3:0]; m_rm = p_rm[g];
          e.res = fake_fma(p_x[g], p_y[g], p_z[g], d[3:0], p_rm[g]);
          e.err = 1'b0; e.due = cyc + LAT + 1;
        end
        sbq.push_back(e);
        glog.push_back(g);
        outstanding = 1; wait_cnt = 0; fma_chk = 1;
        m_ptr = (g + 1) % NREQ;
        p_has[g] = 0;
      end
    end else begin
      chk("req_ready_busy", req_ready, 0);
      wait_cnt++;
      if (wait_cnt > 40) begin
        checks++; errors++;
        $display("FAIL resp_timeout: no response after %0d cycles", wait_cnt);
        outstanding = 0; sbq.delete(); seen_first = 0;
      end
    end
  endtask

  // vmode: 0 random arrivals, 1 all requesters kept valid, 2 no new arrivals
  // rmode: 0 random resp_ready, 1 ready high, 2 ready low
  task automatic drive_cycle(input int vmode, input int rmode);
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (!p_has[i] && ((vmode == 1) || (vmode == 0 && $urandom_range(0, 2) == 0)))
        new_op(i);
      req_valid[i]        = p_has[i];
      req_op[3*i +: 3]    = p_op[i];
      req_x[16*i +: 16]   = p_x[i];
      req_y[16*i +: 16]   = p_y[i];
      req_z[16*i +: 16]   = p_z[i];
      req_rm[2*i +: 2]    = p_rm[i];
    end
    resp_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    @(negedge clk);
    model_check();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((outstanding || p_has[0] || p_has[1] || p_has[2] || p_has[3]) && n < 80) begin
      drive_cycle(2, 1);
      n++;
    end
    chk("drain_done", outstanding, 0);
  endtask

  // Monitor: compares every presented response with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && resp_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_resp: id %0d result %0h", resp_id, resp_result);
        end else begin
          if (!seen_first) begin
            chk("resp_latency", cyc, sbq[0].due);
            seen_first = 1;
          end
          chk("resp_id", resp_id, sbq[0].id);
          chk("resp_result", resp_result, sbq[0].res);
          chk("resp_err", resp_err, sbq[0].err);
          if (resp_ready) begin
            void'(sbq.pop_front());
            seen_first = 0;
            clr_pend = 1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_order[6];
    logic [15:0] bx, by, bz;
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NREQ; i++) p_has[i] = 0;

    // Reset state, with requests asserted that must not be acknowledged
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_fma", {fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negr, fma_negz, fma_rm}, 0);
    chk("rst_resp", {resp_id, resp_result, resp_err}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    model_reset();

    // All requesters valid with resp_ready high: strict rotation from 0
    glog.delete();
    repeat (16) drive_cycle(1, 1);
    for (int k = 0; k < 6; k++) chk("grant_order", glog[k], exp_order[k]);
    drain();

    // Req2 fmul 3C00 * 4000
    p_has[2] = 1; p_op[2] = 3'd2; p_x[2] = 16'h3C00; p_y[2] = 16'h4000;
    p_z[2] = 16'h0000; p_rm[2] = 2'b01;
    drain();

    // Req1 illegal op
    p_has[1] = 1; p_op[1] = 3'd7; p_x[1] = 16'h1234; p_y[1] = 16'h5678;
    p_z[1] = 16'h9ABC; p_rm[1] = 2'b11;
    drain();

    // Response stall: several RESP cycles with resp_ready low, then a new accept
    p_has[3] = 1; p_op[3] = 3'd3; p_x[3] = 16'h4200; p_y[3] = 16'hC000;
    p_z[3] = 16'h3800; p_rm[3] = 2'b10;
    repeat (8) drive_cycle(2, 2);
    p_has[0] = 1; p_op[0] = 3'd0; p_x[0] = 16'h3C00; p_y[0] = 16'h3C00;
    p_z[0] = 16'h0000; p_rm[0] = 2'b00;
    drain();

    // Random traffic
    repeat (500) drive_cycle(0, 0);
    drain();

    // Reset while EXEC: op dropped, pointer back to 0
    p_has[2] = 1; p_op[2] = 3'd5; p_x[2] = 16'h1111; p_y[2] = 16'h2222;
    p_z[2] = 16'h3333; p_rm[2] = 2'b01;
    drive_cycle(2, 1);
    chk("pre_reset_accept", outstanding, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("rst_mid_req_ready", req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_resp_valid", resp_valid, 0);
    model_reset();
    for (int i = 0; i < NREQ; i++) new_op(i);
    drive_cycle(2, 1);   // all four valid: requester 0 must win
    drain();
    repeat (3) drive_cycle(2, 1);

    // LAT=3 instance: fnmsub from req0
    bx = 16'($urandom); by = 16'($urandom); bz = 16'($urandom);
    @(posedge clk); #1;
    b_req_valid = 4'b0001;
    b_req_op[2:0] = 3'd6; b_req_x[15:0] = bx; b_req_y[15:0] = by; b_req_z[15:0] = bz;
    b_req_rm[1:0] = 2'b10;
    @(negedge clk);
    chk("lat3_ready", b_req_ready, 4'b0001);
    @(posedge clk); #1;
    b_req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      if (k <= 3) begin
        chk("lat3_flags", {b_fma_mul, b_fma_add, b_fma_negr, b_fma_negz}, 4'b1111);
        chk("lat3_no_resp", b_resp_valid, 0);
      end else begin
        chk("lat3_resp_valid", b_resp_valid, 1);
        chk("lat3_resp_id", b_resp_id, 0);
        chk("lat3_resp_result", b_resp_result, fake_fma(bx, by, bz, 4'b1111, 2'b10));
        chk("lat3_resp_err", b_resp_err, 0);
      end
    end
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
